// File: rtl/result_writer_pkg.sv
// result_writer_pkg: shared state encodings, lane count and byte-mask helper
package result_writer_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        DRAIN   = ST_DRAIN,
        DONE    = ST_DONE
    } state_t;

    function automatic logic [LANES-1:0] lane_mask(input logic [1:0] last_lane);
        return {LANES{1'b1}} >> (2'd3 - last_lane);
    endfunction

endpackage

// File: rtl/result_writer_if.sv
// result_writer_if: req/ack word-write port towards the output SRAM
interface result_writer_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_DWIDTH = 32
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_DWIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wmask;
    logic                  mem_ack;

    modport master (output mem_req, mem_addr, mem_wdata, mem_wmask, input mem_ack);
    modport slave  (input mem_req, mem_addr, mem_wdata, mem_wmask, output mem_ack);
endinterface

// File: rtl/result_writer_sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO with flush; push on full is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] store [DEPTH];
    logic [LW-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign level   = wp - rp;
    assign full    = level == LW'(DEPTH);
    assign empty   = wp == rp;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = store[rp[AW-1:0]];

    // pointer update; flush empties the queue without touching storage
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end

    // storage write
    always_ff @(posedge clk) begin
        if (do_push) store[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/result_writer.sv
// result_writer: packs result bytes into 32-bit words and drains them to SRAM over req/ack
module result_writer
    import result_writer_pkg::*;
#(
    parameter int RESULT_DWIDTH = 8,
    parameter int MEM_DWIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int CNT_WIDTH     = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [CNT_WIDTH-1:0]     num_results,
    input  logic [RESULT_DWIDTH-1:0] result_data,
    input  logic                     result_valid,
    result_writer_if.master          mem,
    output logic                     busy,
    output logic                     done,
    output logic                     fifo_ovrflow
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    state_t                               state;
    logic [1:0]                           lane;
    logic [CNT_WIDTH-1:0]                 cnt, num, cnt_nx;
    logic [(LANES-1)*RESULT_DWIDTH-1:0]   lbuf;
    logic [ADDR_WIDTH-1:0]                addr;
    logic [MEM_DWIDTH-1:0]                word;
    logic [MEM_DWIDTH+LANES-1:0]          head;
    logic [LW-1:0]                        level;
    logic                                 accept, last, push, pop, full, empty;

    assign accept = state == COLLECT && result_valid && !start;
    assign cnt_nx = cnt + 1'b1;
    assign last   = cnt_nx == num;
    assign push   = accept && (lane == 2'd3 || last);
    assign pop    = mem.mem_req && mem.mem_ack;

    // assemble the outgoing word from buffered lanes plus the incoming byte; unused lanes stay 0
    always_comb begin
        word = '0;
        for (int i = 0; i < LANES - 1; i++)
            if (2'(i) < lane) word[i*RESULT_DWIDTH +: RESULT_DWIDTH] = lbuf[i*RESULT_DWIDTH +: RESULT_DWIDTH];
        word[lane*RESULT_DWIDTH +: RESULT_DWIDTH] = result_data;
    end

    sync_fifo #(.WIDTH(MEM_DWIDTH + LANES), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (start),
        .push  (push),
        .pop   (pop),
        .din   ({word, lane_mask(lane)}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // job FSM, byte counter, lane pointer, write address and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lane  <= '0;
            cnt   <= '0;
            num   <= '0;
            addr  <= '0;
            fifo_ovrflow <= 1'b0;
        end else if (start) begin
            state <= (num_results == '0) ? DONE : COLLECT;
            lane  <= '0;
            cnt   <= '0;
            num   <= num_results;
            addr  <= base_addr;
            fifo_ovrflow <= 1'b0;
        end else begin
            if (pop) addr <= addr + 1'b1;
            if (push && full && !pop) fifo_ovrflow <= 1'b1;
            if (accept) begin
                lane <= lane + 2'd1;
                cnt  <= cnt_nx;
            end
            if (accept && last) state <= DRAIN;
            else if (state == DRAIN && (empty || (pop && level == LW'(1)))) state <= DONE;
            else if (state == DONE) state <= IDLE;
        end
    end

    // partial-word byte buffer for lanes 0..2
    always_ff @(posedge clk) begin
        if (accept && lane != 2'd3) lbuf[lane*RESULT_DWIDTH +: RESULT_DWIDTH] <= result_data;
    end

    assign mem.mem_req  = !empty;
    assign mem.mem_addr = addr;
    assign {mem.mem_wdata, mem.mem_wmask} = empty ? '0 : head;
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule
